// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Entry layout and block-alignment mask.
package fetch_pkg;

  localparam int IW_D = 16;
  localparam int AW_D = 9;

  typedef struct packed {
    logic [IW_D-1:0] inst;
    logic [AW_D-1:0] pc;
  } fq_entry_t;

  function automatic int unsigned align_mask(
    input int unsigned fw
  );
    return ~(fw - 1);
  endfunction

endpackage

// File: rtl/fq_lane_pack.sv
// Compacts one fetched block into a contiguous write vector,
// dropping the lanes below the start offset.
module fq_lane_pack
  import fetch_pkg::*;
#(
  parameter int IW      = IW_D,
  parameter int AW      = AW_D,
  parameter int FETCH_W = 2,
  parameter int OW      = 1,
  parameter int WW      = 2
) (
  input  logic [FETCH_W*IW-1:0] rdata,
  input  logic [AW-1:0]         base,
  input  logic [OW-1:0]         offset,
  output logic [FETCH_W*IW-1:0] w_inst,
  output logic [FETCH_W*AW-1:0] w_pc,
  output logic [WW-1:0]         w_cnt
);

  always_comb begin
    w_inst = '0;
    w_pc   = '0;
    w_cnt  = WW'(FETCH_W) - WW'(offset);
    for (int j = 0; j < FETCH_W; j++) begin
      if (j + int'(offset) < FETCH_W) begin
        w_inst[j*IW +: IW] =
          rdata[(j + int'(offset))*IW +: IW];
        w_pc[j*AW +: AW] =
          base + AW'(j + int'(offset));
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction fetch buffer between IM and issue.
// Reserves space at request time; flush drops queue and in-flight data.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int IW      = IW_D,
  parameter int AW      = AW_D,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [AW-1:0]                flush_pc,
  output logic                         fetch_req,
  output logic [AW-1:0]                fetch_addr,
  input  logic [FETCH_W*IW-1:0]        fetch_rdata,
  output logic [ISSUE_W-1:0]           issue_valid,
  output logic [ISSUE_W*IW-1:0]        issue_inst,
  output logic [ISSUE_W*AW-1:0]        issue_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0] issue_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int WW = $clog2(FETCH_W+1);
  localparam logic [AW-1:0] AMASK =
    AW'(align_mask(FETCH_W));

  fq_entry_t mem [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] fetch_pc, resp_base;
  logic [OW-1:0] off_q, resp_off;
  logic          inflight;

  logic [FETCH_W*IW-1:0] w_inst;
  logic [FETCH_W*AW-1:0] w_pc;
  logic [WW-1:0]         w_cnt;

  int            space;
  logic [CW-1:0] take_c;
  logic          wr_en;

  fq_lane_pack #(
    .IW(IW), .AW(AW), .FETCH_W(FETCH_W),
    .OW(OW), .WW(WW)
  ) u_pack (
    .rdata (fetch_rdata),
    .base  (resp_base),
    .offset(resp_off),
    .w_inst(w_inst),
    .w_pc  (w_pc),
    .w_cnt (w_cnt)
  );

  // in-flight block already owns its slots
  always_comb begin
    space = DEPTH - int'(count)
          - (inflight ? FETCH_W : 0);
    fetch_req  = rst && !flush && space >= FETCH_W;
    fetch_addr = fetch_pc & AMASK;
    take_c = (CW'(issue_take) > count) ?
             count : CW'(issue_take);
    wr_en  = inflight && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fetch_pc  <= '0;
      off_q     <= '0;
      inflight  <= 1'b0;
      resp_base <= '0;
      resp_off  <= '0;
    end else if (flush) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      fetch_pc <= flush_pc;
      off_q    <= OW'(flush_pc & ~AMASK);
    end else begin
      inflight <= fetch_req;
      if (fetch_req) begin
        fetch_pc  <= fetch_addr + AW'(FETCH_W);
        off_q     <= '0;
        resp_base <= fetch_addr;
        resp_off  <= off_q;
      end
      rd_ptr <= rd_ptr + PW'(take_c);
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(w_cnt);
      count <= count
             + (wr_en ? CW'(w_cnt) : '0)
             - take_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int j = 0; j < FETCH_W; j++)
        if (j < int'(w_cnt))
          mem[wr_ptr + PW'(j)] <= '{
            inst: w_inst[j*IW +: IW],
            pc:   w_pc[j*AW +: AW]
          };
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush)
      assert (CW'(issue_take) <= count);
  end

  always_comb begin
    issue_valid = '0;
    issue_inst  = '0;
    issue_pc    = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      issue_valid[i] = rst && (i < int'(count));
      issue_inst[i*IW +: IW] =
        mem[rd_ptr + PW'(i)].inst;
      issue_pc[i*AW +: AW] =
        mem[rd_ptr + PW'(i)].pc;
    end
  end

endmodule
